// File: rtl/gap_phase_sequencer_if.sv
// Control/status bundle between a GAP-TV run controller and the phase sequencer.
// The controller side (master) drives the run request; the sequencer (slave) drives memory strobes and status.
interface gap_phase_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int ITER_W = 8,
   parameter int FRM_W  = 4
) ();
   logic              start;
   logic              hold;
   logic [ITER_W-1:0] n_iter;
   logic [FRM_W-1:0]  f_num;
   logic [ADDR_W-1:0] last_addr;
   logic              ren;
   logic [ADDR_W-1:0] raddr;
   logic              wen;
   logic [ADDR_W-1:0] waddr;
   logic              dx_en;
   logic              dx_diff_rst_n;
   logic [2:0]        phase;
   logic [FRM_W-1:0]  frame_idx;
   logic [ITER_W-1:0] iter_idx;
   logic              busy;
   logic              done;

   modport master (
      output start, hold, n_iter, f_num, last_addr,
      input  ren, raddr, wen, waddr, dx_en, dx_diff_rst_n, phase, frame_idx, iter_idx, busy, done
   );

   modport slave (
      input  start, hold, n_iter, f_num, last_addr,
      output ren, raddr, wen, waddr, dx_en, dx_diff_rst_n, phase, frame_idx, iter_idx, busy, done
   );
endinterface

// File: rtl/gap_phase_sequencer.sv
// Sequences GAP-TV reconstruction: per frame READ rows, DIFF (dx_diff enable), WRITE rows,
// looping over frames and iterations. Every output is a register loaded from next-state values.
module gap_phase_sequencer #(
   parameter int ADDR_W = 8,
   parameter int ITER_W = 8,
   parameter int FRM_W  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   gap_phase_sequencer_if.slave   bus
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DIFF  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] row, row_n, last_q;
   logic [FRM_W-1:0]  frm, frm_n, frm_last_q;
   logic [ITER_W-1:0] itr, itr_n, itr_last_q;
   logic              load, active, work_n;

   // A row/step is consumed only when the cycle that just ended had its strobe high;
   // hold sampled at an edge suppresses the strobe of the following cycle.
   assign active = bus.ren | bus.wen | bus.dx_en;

   always_comb begin
      state_n = state;
      row_n   = row;
      frm_n   = frm;
      itr_n   = itr;
      load    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               row_n   = '0;
               frm_n   = '0;
               itr_n   = '0;
               state_n = (bus.n_iter == '0) ? DONE : READ;
            end
         end
         READ: begin
            if (active) begin
               if (row == last_q) begin
                  row_n   = '0;
                  state_n = DIFF;
               end else begin
                  row_n = row + ADDR_W'(1);
               end
            end
         end
         DIFF: begin
            if (active) begin
               if (row == last_q) begin
                  row_n   = '0;
                  state_n = WRITE;
               end else begin
                  row_n = row + ADDR_W'(1);
               end
            end
         end
         WRITE: begin
            if (active) begin
               if (row == last_q) begin
                  row_n = '0;
                  if (frm != frm_last_q) begin
                     frm_n   = frm + FRM_W'(1);
                     state_n = READ;
                  end else begin
                     frm_n = '0;
                     if (itr != itr_last_q) begin
                        itr_n   = itr + ITER_W'(1);
                        state_n = READ;
                     end else begin
                        state_n = DONE;
                     end
                  end
               end else begin
                  row_n = row + ADDR_W'(1);
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      work_n = (state_n == READ) || (state_n == DIFF) || (state_n == WRITE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         row               <= '0;
         frm               <= '0;
         itr               <= '0;
         last_q            <= '0;
         frm_last_q        <= '0;
         itr_last_q        <= '0;
         bus.ren           <= 1'b0;
         bus.raddr         <= '0;
         bus.wen           <= 1'b0;
         bus.waddr         <= '0;
         bus.dx_en         <= 1'b0;
         bus.dx_diff_rst_n <= 1'b0;
         bus.phase         <= 3'd0;
         bus.frame_idx     <= '0;
         bus.iter_idx      <= '0;
         bus.busy          <= 1'b0;
         bus.done          <= 1'b0;
      end else begin
         state <= state_n;
         row   <= row_n;
         frm   <= frm_n;
         itr   <= itr_n;
         if (load) begin
            last_q     <= bus.last_addr;
            // f_num of zero behaves as a single frame
            frm_last_q <= (bus.f_num == '0) ? '0 : bus.f_num - FRM_W'(1);
            itr_last_q <= bus.n_iter - ITER_W'(1);
         end
         bus.ren           <= work_n && !bus.hold && (state_n == READ);
         bus.wen           <= work_n && !bus.hold && (state_n == WRITE);
         bus.dx_en         <= work_n && !bus.hold && (state_n == DIFF);
         bus.raddr         <= (state_n == READ)  ? row_n : '0;
         bus.waddr         <= (state_n == WRITE) ? row_n : '0;
         bus.dx_diff_rst_n <= !((state_n == DIFF) && (state != DIFF));
         bus.phase         <= state_n;
         bus.frame_idx     <= frm_n;
         bus.iter_idx      <= itr_n;
         bus.busy          <= (state_n != IDLE);
         bus.done          <= (state_n == DONE);
      end
   end
endmodule

// File: tb/tb_gap_phase_sequencer.sv
// Bench for gap_phase_sequencer: each run is expanded into the ordered list of row operations
// it must perform, and the DUT is walked cycle by cycle against that list under random stalls.
module tb_gap_phase_sequencer;
   localparam int ADDR_W = 8;
   localparam int ITER_W = 8;
   localparam int FRM_W  = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   gap_phase_sequencer_if #(.ADDR_W(ADDR_W), .ITER_W(ITER_W), .FRM_W(FRM_W)) bus ();

   gap_phase_sequencer #(.ADDR_W(ADDR_W), .ITER_W(ITER_W), .FRM_W(FRM_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // kind: 1 = read row, 2 = dx_diff step, 3 = write row
   typedef struct {
      int kind;
      int addr;
      int frm;
      int itr;
   } op_t;

   op_t q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_ren"}, 32'(bus.ren), 0);
      chk({tag, "_wen"}, 32'(bus.wen), 0);
      chk({tag, "_dx_en"}, 32'(bus.dx_en), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_raddr"}, 32'(bus.raddr), 0);
      chk({tag, "_waddr"}, 32'(bus.waddr), 0);
      chk({tag, "_phase"}, 32'(bus.phase), 0);
      chk({tag, "_frame"}, 32'(bus.frame_idx), 0);
      chk({tag, "_iter"}, 32'(bus.iter_idx), 0);
      chk({tag, "_clr"}, 32'(bus.dx_diff_rst_n), 0);
   endtask

   // One complete run. done_at: expected index of the done cycle, counting the first cycle after
   // the acceptance edge as 1 (0 skips that check). hold_dir stalls 3 edges right after row 3 is read.
   task automatic run_job(input int ni, input int fn, input int la, input int pct,
                          input bit hold_dir, input bit dup_start, input int done_at);
      int  fe, total, stalls, cyc, prev_kind, held;
      bit  ph, done_seen, dir_done;
      op_t h;
      fe = (fn == 0) ? 1 : fn;
      q.delete();
      for (int it = 0; it < ni; it++)
         for (int f = 0; f < fe; f++)
            for (int k = 1; k <= 3; k++)
               for (int a = 0; a <= la; a++) q.push_back('{k, a, f, it});
      total = q.size();
      stalls = 0; cyc = 0; prev_kind = 0; held = 0; done_seen = 0; dir_done = 0;
      bus.n_iter    = ITER_W'(ni);
      bus.f_num     = FRM_W'(fn);
      bus.last_addr = ADDR_W'(la);
      bus.start     = 1'b1;
      bus.hold      = ($urandom_range(99) < pct);
      ph = bus.hold;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (!done_seen && cyc < 5000) begin
         cyc++;
         if (q.size() == 0) begin
            chk("done_phase", 32'(bus.phase), 4);
            chk("done_pulse", 32'(bus.done), 1);
            chk("done_busy", 32'(bus.busy), 1);
            chk("done_strobes", 32'({bus.ren, bus.wen, bus.dx_en}), 0);
            chk("run_len", cyc, total + stalls + 1);
            if (done_at != 0) chk("done_cycle", cyc, done_at);
            done_seen = 1;
         end else begin
            h = q[0];
            chk("phase", 32'(bus.phase), h.kind);
            chk("busy", 32'(bus.busy), 1);
            chk("done_low", 32'(bus.done), 0);
            chk("clr", 32'(bus.dx_diff_rst_n), (h.kind == 2 && prev_kind != 2) ? 0 : 1);
            chk("frame_idx", 32'(bus.frame_idx), h.frm);
            chk("iter_idx", 32'(bus.iter_idx), h.itr);
            if (ph) begin
               stalls++;
               chk("stall_strobes", 32'({bus.ren, bus.wen, bus.dx_en}), 0);
               if (h.kind == 1) chk("stall_raddr", 32'(bus.raddr), h.addr);
               if (h.kind == 3) chk("stall_waddr", 32'(bus.waddr), h.addr);
            end else begin
               chk("strobes", 32'({bus.ren, bus.wen, bus.dx_en}),
                   (h.kind == 1) ? 4 : (h.kind == 2) ? 1 : 2);
               if (h.kind == 1) chk("raddr", 32'(bus.raddr), h.addr);
               if (h.kind == 3) chk("waddr", 32'(bus.waddr), h.addr);
               void'(q.pop_front());
            end
            prev_kind = h.kind;
         end
         // a second start while the first frame is still being read must be ignored
         if (dup_start)
            bus.start = (q.size() > 0 && q[0].kind == 1 && q[0].frm == 0 && q[0].itr == 0);
         if (hold_dir && !dir_done && bus.ren && bus.raddr == 3) begin
            held = 3;
            dir_done = 1;
         end
         if (held > 0) begin
            bus.hold = 1'b1;
            held--;
         end else begin
            bus.hold = ($urandom_range(99) < pct);
         end
         ph = bus.hold;
         @(posedge clk); #1;
      end
      if (!done_seen) chk("run_timeout", 0, 1);
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      chk("idle_phase", 32'(bus.phase), 0);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_done", 32'(bus.done), 0);
   endtask

   initial begin
      int guard;
      bus.start = 1'b0; bus.hold = 1'b0;
      bus.n_iter = '0; bus.f_num = '0; bus.last_addr = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 chk_reset_values("reset_async");
      repeat (2) @(posedge clk);
      #1 chk_reset_values("reset_held");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("clr_after_release", 32'(bus.dx_diff_rst_n), 1);
      chk("idle_after_release", 32'(bus.phase), 0);

      // single frame, single iteration, 8 rows
      run_job(1, 1, 7, 0, 0, 0, 25);
      // 2 frames x 3 iterations, 4 rows
      run_job(3, 2, 3, 0, 0, 0, 0);
      // 3-cycle stall right after row 3: stalled cycles show raddr 4
      run_job(1, 1, 7, 0, 1, 0, 28);
      // zero iterations: straight to DONE
      run_job(0, 2, 5, 0, 0, 0, 1);
      // hold during IDLE/DONE irrelevant, start with hold accepted
      run_job(0, 1, 3, 100, 0, 0, 1);
      // duplicate start during READ
      run_job(1, 1, 5, 0, 0, 1, 19);
      // full address range without wrap
      run_job(1, 1, 255, 0, 0, 0, 769);
      // minimal rows, f_num 0 treated as 1
      run_job(2, 0, 0, 0, 0, 0, 7);
      // randomized runs with random stalls
      for (int n = 0; n < 8; n++)
         run_job($urandom_range(3), $urandom_range(3), $urandom_range(6),
                 $urandom_range(40), 0, $urandom_range(1), 0);

      // reset during WRITE aborts the run with no done pulse
      bus.n_iter = 8'd2; bus.f_num = 4'd2; bus.last_addr = 8'd4;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      guard = 0;
      while (bus.phase != 3'd3 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("reach_write", 32'(bus.phase), 3);
      #2 rst_n = 1'b0;
      #1 chk_reset_values("abort");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_clr_release", 32'(bus.dx_diff_rst_n), 1);
      for (int c = 0; c < 30; c++) begin
         chk("abort_no_done", 32'({bus.done, bus.busy, bus.ren, bus.wen, bus.dx_en}), 0);
         @(posedge clk); #1;
      end
      chk("abort_idle", 32'(bus.phase), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
